// File: rtl/cross_window_platedetection_pkg.sv
// Shared types for the plate-detection cross-window generator.
// Holds the default pixel width and the window FSM states.
package cross_window_platedetection_pkg;

  localparam int PIXEL_IN_WIDTH = 8;

  typedef enum logic [1:0] {
    FILL,
    STREAM,
    FLUSH
  } state_t;

endpackage

// File: rtl/line_buffer_platedetection.sv
// Shift-on-enable pixel delay line; contents are never reset.
// Output is the oldest stored sample, DEPTH enables ago.
module line_buffer_platedetection #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (en_i) begin
      mem_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  assign q_o = mem_q[DEPTH-1];

endmodule

// File: rtl/cross_window_platedetection.sv
// Raster-stream to 5-pixel cross window generator.
// Emits one registered window per image pixel; out-of-image taps read 0.
import cross_window_platedetection_pkg::*;

module cross_window_platedetection #(
  parameter int PIXEL_WIDTH = PIXEL_IN_WIDTH,
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  input  logic [PIXEL_WIDTH-1:0] i_pixel,
  output logic                   o_ready,
  output logic                   o_start_kernel,
  output logic [PIXEL_WIDTH-1:0] o_pixel_up,
  output logic [PIXEL_WIDTH-1:0] o_pixel_down,
  output logic [PIXEL_WIDTH-1:0] o_pixel_left,
  output logic [PIXEL_WIDTH-1:0] o_pixel_right,
  output logic [PIXEL_WIDTH-1:0] o_pixel_center,
  output logic                   o_frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] WMAX = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] HMAX = RW'(IMG_HEIGHT - 1);

  state_t state_q, state_d;
  logic [CW-1:0] in_col_q, in_col_d, out_col_q, out_col_d;
  logic [RW-1:0] in_row_q, in_row_d, out_row_q, out_row_d;
  logic acc, shift, emit, last;

  logic [PIXEL_WIDTH-1:0] right_w, up_w, c_q, l_q;
  logic [PIXEL_WIDTH-1:0] up_q, down_q, left_q, right_q, center_q;
  logic start_q, done_q;

  line_buffer_platedetection #(
    .DEPTH(IMG_WIDTH - 1),
    .WIDTH(PIXEL_WIDTH)
  ) u_lb_right (
    .clk (clk),
    .en_i(shift),
    .d_i (i_pixel),
    .q_o (right_w)
  );

  line_buffer_platedetection #(
    .DEPTH(IMG_WIDTH),
    .WIDTH(PIXEL_WIDTH)
  ) u_lb_up (
    .clk (clk),
    .en_i(shift),
    .d_i (c_q),
    .q_o (up_w)
  );

  assign o_ready = (state_q != FLUSH);
  assign acc     = i_valid && o_ready;

  always_comb begin
    state_d   = state_q;
    shift     = 1'b0;
    emit      = 1'b0;
    last      = 1'b0;
    in_col_d  = in_col_q;
    in_row_d  = in_row_q;
    out_col_d = out_col_q;
    out_row_d = out_row_q;
    unique case (state_q)
      FILL: begin
        if (acc) begin
          shift = 1'b1;
          if (in_col_q == WMAX) state_d = STREAM;
        end
      end
      STREAM: begin
        if (acc) begin
          shift = 1'b1;
          emit  = 1'b1;
          if (in_col_q == WMAX && in_row_q == HMAX) state_d = FLUSH;
        end
      end
      FLUSH: begin
        // Clock the pipeline with a dummy pixel; its down tap is masked.
        shift = 1'b1;
        emit  = 1'b1;
        if (out_col_q == WMAX) begin
          last    = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
    if (acc) begin
      if (in_col_q == WMAX) begin
        in_col_d = '0;
        in_row_d = (in_row_q == HMAX) ? '0 : in_row_q + 1'b1;
      end else begin
        in_col_d = in_col_q + 1'b1;
      end
    end
    if (emit) begin
      if (out_col_q == WMAX) begin
        out_col_d = '0;
        out_row_d = (out_row_q == HMAX) ? '0 : out_row_q + 1'b1;
      end else begin
        out_col_d = out_col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (shift) begin
      c_q <= right_w;
      l_q <= c_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      in_col_q  <= '0;
      in_row_q  <= '0;
      out_col_q <= '0;
      out_row_q <= '0;
      up_q      <= '0;
      down_q    <= '0;
      left_q    <= '0;
      right_q   <= '0;
      center_q  <= '0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_col_q  <= in_col_d;
      in_row_q  <= in_row_d;
      out_col_q <= out_col_d;
      out_row_q <= out_row_d;
      start_q   <= emit;
      done_q    <= last;
      if (emit) begin
        up_q     <= (out_row_q == '0)   ? '0 : up_w;
        down_q   <= (out_row_q == HMAX) ? '0 : i_pixel;
        left_q   <= (out_col_q == '0)   ? '0 : l_q;
        right_q  <= (out_col_q == WMAX) ? '0 : right_w;
        center_q <= c_q;
      end
    end
  end

  assign o_start_kernel = start_q;
  assign o_frame_done   = done_q;
  assign o_pixel_up     = up_q;
  assign o_pixel_down   = down_q;
  assign o_pixel_left   = left_q;
  assign o_pixel_right  = right_q;
  assign o_pixel_center = center_q;

endmodule

// File: tb/tb_cross_window_platedetection.sv
// Directed bench for the cross-window generator on a 4x3 image.
// Windows are collected on strobes and compared against an image model.
module tb_cross_window_platedetection;

  localparam int W = 4;
  localparam int H = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_valid = 1'b0;
  logic [7:0] i_pixel = 8'h00;
  logic       o_ready, o_start_kernel, o_frame_done;
  logic [7:0] o_pixel_up, o_pixel_down, o_pixel_left;
  logic [7:0] o_pixel_right, o_pixel_center;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] up;
    logic [7:0] down;
    logic [7:0] left;
    logic [7:0] right;
    logic [7:0] center;
    logic       done;
  } win_t;

  win_t win_q[$];

  cross_window_platedetection #(
    .PIXEL_WIDTH(8),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_valid       (i_valid),
    .i_pixel       (i_pixel),
    .o_ready       (o_ready),
    .o_start_kernel(o_start_kernel),
    .o_pixel_up    (o_pixel_up),
    .o_pixel_down  (o_pixel_down),
    .o_pixel_left  (o_pixel_left),
    .o_pixel_right (o_pixel_right),
    .o_pixel_center(o_pixel_center),
    .o_frame_done  (o_frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_start_kernel === 1'b1) begin
      win_q.push_back({o_pixel_up, o_pixel_down, o_pixel_left,
                       o_pixel_right, o_pixel_center, o_frame_done});
    end
  end

  function automatic logic [7:0] px(int base, int r, int c);
    if (r < 0 || r >= H || c < 0 || c >= W) return 8'h00;
    return 8'(base + r * W + c);
  endfunction

  function automatic win_t exp_win(int base, int n);
    win_t e;
    int r = n / W;
    int c = n % W;
    e.up     = px(base, r - 1, c);
    e.down   = px(base, r + 1, c);
    e.left   = px(base, r, c - 1);
    e.right  = px(base, r, c + 1);
    e.center = px(base, r, c);
    e.done   = (n == W * H - 1);
    return e;
  endfunction

  function automatic logic [7:0] max2(logic [7:0] a, logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

  // Reference dilation taken straight from the image.
  function automatic logic [7:0] dil_model(int base, int n);
    int r = n / W;
    int c = n % W;
    logic [7:0] m;
    m = px(base, r, c);
    m = max2(m, px(base, r - 1, c));
    m = max2(m, px(base, r + 1, c));
    m = max2(m, px(base, r, c - 1));
    m = max2(m, px(base, r, c + 1));
    return m;
  endfunction

  function automatic logic [7:0] dil_dut(win_t w);
    logic [7:0] m;
    m = max2(w.center, w.up);
    m = max2(m, w.down);
    m = max2(m, w.left);
    m = max2(m, w.right);
    return m;
  endfunction

  // Present one pixel and return at the negedge after it is accepted.
  task automatic send(input logic [7:0] v, input bit gap, output int waited);
    int guard = 0;
    waited = 0;
    if (gap && $urandom_range(0, 2) == 0) begin
      i_valid = 1'b0;
      repeat ($urandom_range(1, 2)) @(negedge clk);
    end
    i_valid = 1'b1;
    i_pixel = v;
    while (o_ready !== 1'b1 && guard < 50) begin
      waited++;
      guard++;
      @(negedge clk);
    end
    if (guard >= 50) begin
      checks++;
      failures++;
      $display("FAIL send_timeout pixel=%0d got ready=%b need 1", v, o_ready);
    end
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic wait_flush(input bit hold, output int n);
    n = 0;
    if (hold) begin
      i_valid = 1'b1;
      i_pixel = 8'hEE;
    end
    while (o_ready !== 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    i_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_pixel_up, o_pixel_down, o_pixel_left, o_pixel_right,
         o_pixel_center} !== 40'h0) begin
      failures++;
      $display("FAIL reset_pixels got=%h need 0", {o_pixel_up,
               o_pixel_down, o_pixel_left, o_pixel_right, o_pixel_center});
    end
    checks++;
    if (o_start_kernel !== 1'b0 || o_frame_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_strobes got=%b%b need 00",
               o_start_kernel, o_frame_done);
    end
    checks++;
    if (o_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b need 1", o_ready);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stream();
    int w;
    int n;
    win_t e;
    win_q.delete();
    for (int k = 0; k < W * H; k++) begin
      send(8'(k + 1), 1'b0, w);
      if (k == W - 1) begin
        checks++;
        if (o_start_kernel !== 1'b0 || win_q.size() != 0) begin
          failures++;
          $display("FAIL fill_no_output got strobe=%b n=%0d need 0",
                   o_start_kernel, win_q.size());
        end
      end
      if (k == W) begin
        checks++;
        if ({o_start_kernel, o_pixel_up, o_pixel_left, o_pixel_center,
             o_pixel_right, o_pixel_down} !== {1'b1, 40'h00_00_01_02_05}) begin
          failures++;
          $display("FAIL first_window got s=%b u=%0d l=%0d c=%0d r=%0d d=%0d need 1 0 0 1 2 5",
                   o_start_kernel, o_pixel_up, o_pixel_left, o_pixel_center,
                   o_pixel_right, o_pixel_down);
        end
      end
      if (k == 9) begin
        checks++;
        if ({o_start_kernel, o_pixel_up, o_pixel_left, o_pixel_center,
             o_pixel_right, o_pixel_down} !== {1'b1, 40'h02_05_06_07_0A}) begin
          failures++;
          $display("FAIL interior_window got u=%0d l=%0d c=%0d r=%0d d=%0d need 2 5 6 7 10",
                   o_pixel_up, o_pixel_left, o_pixel_center,
                   o_pixel_right, o_pixel_down);
        end
      end
    end
    wait_flush(1'b0, n);
    @(negedge clk);
    #1;
    checks++;
    if (n != W) begin
      failures++;
      $display("FAIL flush_ready_low got=%0d need %0d", n, W);
    end
    checks++;
    if (win_q.size() != W * H) begin
      failures++;
      $display("FAIL stream_count got=%0d need %0d", win_q.size(), W * H);
    end else begin
      checks++;
      if (win_q[W*H-1] !== {40'h08_00_0B_00_0C, 1'b1}) begin
        failures++;
        $display("FAIL last_window got=%h need %h", win_q[W*H-1],
                 {40'h08_00_0B_00_0C, 1'b1});
      end
      for (int i = 0; i < W * H; i++) begin
        e = exp_win(1, i);
        checks++;
        if (win_q[i] !== e) begin
          failures++;
          $display("FAIL stream_win[%0d] got=%h need %h", i, win_q[i], e);
        end
      end
    end
    checks++;
    if (o_start_kernel !== 1'b0 || o_pixel_center !== 8'd12) begin
      failures++;
      $display("FAIL hold_after_flush got s=%b c=%0d need 0 12",
               o_start_kernel, o_pixel_center);
    end
  endtask

  task automatic test_gaps();
    int w;
    int n;
    win_t e;
    win_q.delete();
    for (int k = 0; k < W * H; k++) begin
      send(8'(k + 1), 1'b1, w);
    end
    wait_flush(1'b1, n);
    @(negedge clk);
    #1;
    checks++;
    if (n != W) begin
      failures++;
      $display("FAIL gaps_flush_len got=%0d need %0d", n, W);
    end
    checks++;
    if (win_q.size() != W * H) begin
      failures++;
      $display("FAIL gaps_count got=%0d need %0d", win_q.size(), W * H);
    end else begin
      for (int i = 0; i < W * H; i++) begin
        e = exp_win(1, i);
        checks++;
        if (win_q[i] !== e) begin
          failures++;
          $display("FAIL gaps_win[%0d] got=%h need %h", i, win_q[i], e);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int w;
    int n;
    win_t e;
    for (int k = 0; k < 7; k++) begin
      send(8'(k + 1), 1'b0, w);
    end
    #1;
    win_q.delete();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_start_kernel, o_frame_done, o_pixel_up, o_pixel_down,
         o_pixel_left, o_pixel_right, o_pixel_center} !== 42'h0) begin
      failures++;
      $display("FAIL midreset_outputs got s=%b d=%b px=%h need all 0",
               o_start_kernel, o_frame_done, {o_pixel_up, o_pixel_down,
               o_pixel_left, o_pixel_right, o_pixel_center});
    end
    checks++;
    if (o_ready !== 1'b1) begin
      failures++;
      $display("FAIL midreset_ready got=%b need 1", o_ready);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (win_q.size() != 0) begin
      failures++;
      $display("FAIL aborted_strobes got=%0d need 0", win_q.size());
    end
    for (int k = 0; k < W * H; k++) begin
      send(8'(k + 1), 1'b0, w);
    end
    wait_flush(1'b0, n);
    @(negedge clk);
    #1;
    checks++;
    if (win_q.size() != W * H) begin
      failures++;
      $display("FAIL midreset_count got=%0d need %0d", win_q.size(), W * H);
    end else begin
      for (int i = 0; i < W * H; i++) begin
        e = exp_win(1, i);
        checks++;
        if (win_q[i] !== e) begin
          failures++;
          $display("FAIL midreset_win[%0d] got=%h need %h", i, win_q[i], e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int w;
    int n;
    int base;
    int dones;
    win_q.delete();
    for (int f = 0; f < 2; f++) begin
      base = (f == 0) ? 1 : 21;
      for (int k = 0; k < W * H; k++) begin
        send(8'(base + k), 1'b0, w);
        if (f == 1 && k == 0) begin
          checks++;
          if (w != W) begin
            failures++;
            $display("FAIL b2b_first_accept waited=%0d need %0d", w, W);
          end
        end
      end
    end
    wait_flush(1'b0, n);
    @(negedge clk);
    #1;
    checks++;
    if (win_q.size() != 2 * W * H) begin
      failures++;
      $display("FAIL b2b_count got=%0d need %0d", win_q.size(), 2 * W * H);
    end else begin
      dones = 0;
      for (int i = 0; i < 2 * W * H; i++) begin
        base = (i < W * H) ? 1 : 21;
        dones += int'(win_q[i].done);
        checks++;
        if (dil_dut(win_q[i]) !== dil_model(base, i % (W * H))) begin
          failures++;
          $display("FAIL b2b_dilate[%0d] got=%0d need %0d", i,
                   dil_dut(win_q[i]), dil_model(base, i % (W * H)));
        end
      end
      checks++;
      if (dones != 2) begin
        failures++;
        $display("FAIL b2b_frame_done got=%0d need 2", dones);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
